// File: rtl/counter_en_mon_pkg.sv
// counter_en_mon_pkg: shared types and constants for the counter_en monitor.
//   mon_st_t      : tracking FSM state (SYNC = acquiring, LOCK = reporting)
//   DIR_UP/DIR_DN : values for the INC_DEC parameter
package counter_en_mon_pkg;

    typedef enum logic {
        SYNC = 1'b0,
        LOCK = 1'b1
    } mon_st_t;

    localparam bit DIR_UP = 1'b1;
    localparam bit DIR_DN = 1'b0;

endpackage

// File: rtl/counter_en_mon_satcnt.sv
// counter_en_mon_satcnt: saturating event counter with synchronous clear.
// If inc and clr arrive together, the new event wins and the count restarts at 1.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : count one event this edge
//   clr        : synchronous clear
//   value      : current count, sticks at all-ones
module counter_en_mon_satcnt #(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [ERR_W-1:0] value
);

    logic [ERR_W-1:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (inc) begin
            if (clr)
                value_d = ERR_W'(1);
            else if (value_q != {ERR_W{1'b1}})
                value_d = value_q + ERR_W'(1);
        end else if (clr) begin
            value_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) value_q <= '0;
        else        value_q <= value_d;
    end

    assign value = value_q;

endmodule

// File: rtl/counter_en_mon.sv
// counter_en_mon: passive checker for a counter_en instance.
// Registers the observed (en, cnt) pair each edge, predicts the next cnt and
// compares. A SYNC/LOCK FSM only reports mismatches once LOCK_CYC consecutive
// predictions have held, so start-up and post-error resync stay silent.
// Ports:
//   clk, rst_n : shared with the observed counter (async active-low reset)
//   en, cnt    : observed counter enable / count
//   clr_err    : synchronous clear of err_sticky and err_cnt
//   locked     : tracking established, mismatches are reported
//   err        : one-cycle pulse per reported mismatch
//   err_sticky : latched err, cleared by clr_err or reset
//   err_cnt    : saturating count of reported mismatches
// Build option: define COUNTER_EN_MON_SVA_EN to add assertions and covers.
module counter_en_mon
    import counter_en_mon_pkg::*;
#(
    parameter int W        = 8,
    parameter bit INC_DEC  = DIR_UP,
    parameter int LOCK_CYC = 2,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [W-1:0]     cnt,
    input  logic             clr_err,
    output logic             locked,
    output logic             err,
    output logic             err_sticky,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int MC_W = $clog2(LOCK_CYC + 1);

    mon_st_t        st_q, st_d;
    logic [W-1:0]   prev_cnt_q;
    logic           prev_en_q;
    logic           prev_vld_q;
    logic [MC_W-1:0] mc_q, mc_d;
    logic           err_q, err_d;
    logic           sticky_q, sticky_d;
    logic [W-1:0]   exp_val;
    logic           match;

    // Prediction wraps naturally modulo 2**W.
    always_comb begin
        exp_val = prev_cnt_q;
        if (prev_en_q)
            exp_val = (INC_DEC == DIR_UP) ? prev_cnt_q + W'(1) : prev_cnt_q - W'(1);
    end

    assign match = (cnt == exp_val);

    // Branches test 'match' positively so an X/Z cnt falls into the mismatch path.
    always_comb begin
        st_d  = st_q;
        mc_d  = mc_q;
        err_d = 1'b0;
        if (prev_vld_q) begin
            case (st_q)
                SYNC: begin
                    if (match) begin
                        mc_d = mc_q + MC_W'(1);
                        if (int'(mc_q) + 1 >= LOCK_CYC) st_d = LOCK;
                    end else begin
                        mc_d = '0;
                    end
                end
                LOCK: begin
                    if (match) begin
                        st_d = LOCK;
                    end else begin
                        err_d = 1'b1;
                        st_d  = SYNC;
                        mc_d  = '0;
                    end
                end
                default: st_d = SYNC;
            endcase
        end
    end

    always_comb begin
        sticky_d = sticky_q;
        if (err_d)        sticky_d = 1'b1;
        else if (clr_err) sticky_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q       <= SYNC;
            prev_cnt_q <= '0;
            prev_en_q  <= 1'b0;
            prev_vld_q <= 1'b0;
            mc_q       <= '0;
            err_q      <= 1'b0;
            sticky_q   <= 1'b0;
        end else begin
            st_q       <= st_d;
            prev_cnt_q <= cnt;
            prev_en_q  <= en;
            prev_vld_q <= 1'b1;
            mc_q       <= mc_d;
            err_q      <= err_d;
            sticky_q   <= sticky_d;
        end
    end

    counter_en_mon_satcnt #(.ERR_W(ERR_W)) u_satcnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (err_d),
        .clr   (clr_err),
        .value (err_cnt)
    );

    assign locked     = (st_q == LOCK);
    assign err        = err_q;
    assign err_sticky = sticky_q;

`ifdef COUNTER_EN_MON_SVA_EN
    a_mismatch_err: assert property (@(posedge clk) disable iff (!rst_n)
        (locked && prev_vld_q && !match) |=> err);

    a_err_pulse: assert property (@(posedge clk) disable iff (!rst_n)
        err |=> !err);

    a_errcnt_mono: assert property (@(posedge clk) disable iff (!rst_n)
        1'b1 |=> ($past(clr_err) || (err_cnt >= $past(err_cnt))));

    c_up_wrap: cover property (@(posedge clk) disable iff (!rst_n)
        locked && prev_vld_q && prev_en_q && (INC_DEC == DIR_UP)
        && (prev_cnt_q == {W{1'b1}}) && (cnt == '0));

    c_dn_wrap: cover property (@(posedge clk) disable iff (!rst_n)
        locked && prev_vld_q && prev_en_q && (INC_DEC == DIR_DN)
        && (prev_cnt_q == '0) && (cnt == {W{1'b1}}));
`else
`endif

endmodule

// File: tb/tb_counter_en_mon.sv
// tb_counter_en_mon: drives an up-counting and a down-counting monitor with
// behaviourally generated counter traffic plus injected faults.
module tb_counter_en_mon;

    localparam int LOCK_CYC = 2;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, clr_err;
    logic       en_u, en_d;
    logic [7:0] cnt_u, cnt_d;
    logic       lk_u, er_u, st_u, lk_d, er_d, st_d;
    logic [7:0] ec_u, ec_d;

    int n_chk  = 0;
    int n_pass = 0;

    // Next value a correct counter would present, per instance.
    logic [7:0] cu, cd;

    typedef struct packed {
        logic       dn;
        logic       lk;
        logic       er;
        logic       st;
        logic [7:0] ec;
    } exp_t;

    typedef struct packed {
        logic       e;
        logic [7:0] c;
        logic       clr;
        logic       lk;
        logic       er;
        logic       st;
        logic [7:0] ec;
    } vec_t;

    exp_t sb[$];
    exp_t xr;
    vec_t tv[18];

    counter_en_mon #(.W(8), .INC_DEC(1'b1), .LOCK_CYC(LOCK_CYC), .ERR_W(8)) u_up (
        .clk(clk), .rst_n(rst_n), .en(en_u), .cnt(cnt_u), .clr_err(clr_err),
        .locked(lk_u), .err(er_u), .err_sticky(st_u), .err_cnt(ec_u)
    );

    counter_en_mon #(.W(8), .INC_DEC(1'b0), .LOCK_CYC(LOCK_CYC), .ERR_W(8)) u_dn (
        .clk(clk), .rst_n(rst_n), .en(en_d), .cnt(cnt_d), .clr_err(clr_err),
        .locked(lk_d), .err(er_d), .err_sticky(st_d), .err_cnt(ec_d)
    );

    task automatic chk1(input string name, input logic act, input logic req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, req);
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    // Drive one cycle on the selected instance; the other one is held idle
    // (en=0, cnt unchanged) so it stays consistent. Expected outputs after the
    // next edge go to the scoreboard.
    task automatic step(input logic dn, input logic e, input logic [7:0] c, input logic clr,
                        input logic lk, input logic er, input logic st, input logic [7:0] ec);
        @(negedge clk);
        if (dn) begin
            en_d = e; cnt_d = c; en_u = 1'b0; cnt_u = cu;
            cd = e ? c - 8'd1 : c;
        end else begin
            en_u = e; cnt_u = c; en_d = 1'b0; cnt_d = cd;
            cu = e ? c + 8'd1 : c;
        end
        clr_err = clr;
        sb.push_back('{dn, lk, er, st, ec});
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            xr = sb.pop_front();
            if (xr.dn) begin
                chk1("dn_locked", lk_d, xr.lk);
                chk1("dn_err", er_d, xr.er);
                chk1("dn_sticky", st_d, xr.st);
                chk8("dn_errcnt", ec_d, xr.ec);
            end else begin
                chk1("up_locked", lk_u, xr.lk);
                chk1("up_err", er_u, xr.er);
                chk1("up_sticky", st_u, xr.st);
                chk8("up_errcnt", ec_u, xr.ec);
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk1({tag, "_up_locked"}, lk_u, 1'b0);
        chk1({tag, "_up_err"}, er_u, 1'b0);
        chk1({tag, "_up_sticky"}, st_u, 1'b0);
        chk8({tag, "_up_errcnt"}, ec_u, 8'd0);
        chk1({tag, "_dn_locked"}, lk_d, 1'b0);
        chk1({tag, "_dn_err"}, er_d, 1'b0);
        chk1({tag, "_dn_sticky"}, st_d, 1'b0);
        chk8({tag, "_dn_errcnt"}, ec_d, 8'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; en_u = 1'b0; en_d = 1'b0; cnt_u = cu; cnt_d = cd; clr_err = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] ecx;
        logic       e;

        rst_n = 1'b0; clr_err = 1'b0;
        en_u = 1'b0; en_d = 1'b0; cnt_u = 8'h00; cnt_d = 8'h00;
        cu = 8'h00; cd = 8'h00;

        // Fault sequence: lock, +2 glitch, resync, en=0 with change, en=1 with hold, clr.
        tv[0]  = '{1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tv[1]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tv[2]  = '{1'b0, 8'h12, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        tv[3]  = '{1'b0, 8'h12, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        tv[4]  = '{1'b1, 8'h12, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        tv[5]  = '{1'b1, 8'h15, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1};
        tv[6]  = '{1'b1, 8'h14, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
        tv[7]  = '{1'b1, 8'h15, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
        tv[8]  = '{1'b0, 8'h16, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1};
        tv[9]  = '{1'b0, 8'h17, 1'b0, 1'b0, 1'b1, 1'b1, 8'd2};
        tv[10] = '{1'b1, 8'h17, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2};
        tv[11] = '{1'b1, 8'h18, 1'b0, 1'b1, 1'b0, 1'b1, 8'd2};
        tv[12] = '{1'b1, 8'h18, 1'b0, 1'b0, 1'b1, 1'b1, 8'd3};
        tv[13] = '{1'b0, 8'h18, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3};
        tv[14] = '{1'b0, 8'h18, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3};
        tv[15] = '{1'b0, 8'h18, 1'b0, 1'b1, 1'b0, 1'b1, 8'd3};
        tv[16] = '{1'b0, 8'h18, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
        tv[17] = '{1'b0, 8'h18, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};

        // Reset state
        repeat (2) @(posedge clk);
        #2 chk_all_zero("reset");
        #1 rst_n = 1'b1;

        // Random enable against a correct up counter
        for (int i = 0; i < 2000; i++) begin
            e = 1'($urandom_range(0, 1));
            step(1'b0, e, cu, 1'b0, (i >= LOCK_CYC), 1'b0, 1'b0, 8'd0);
        end

        // Up wrap FF -> 00 while locked
        while (cu != 8'hFF) step(1'b0, 1'b1, cu, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b1, cu, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b0, cu, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);

        // Down wrap 00 -> FF while locked (down instance has idled at 00)
        step(1'b1, 1'b1, cd, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        step(1'b1, 1'b1, cd, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        step(1'b1, 1'b0, cd, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        step(1'b1, 1'b0, cd, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);

        // Table-driven fault vectors from a fresh reset
        do_reset();
        for (int i = 0; i < 18; i++)
            step(1'b0, tv[i].e, tv[i].c, tv[i].clr, tv[i].lk, tv[i].er, tv[i].st, tv[i].ec);

        // 300 injected errors, each followed by a relock
        for (int n = 1; n <= 300; n++) begin
            ecx = (n > 255) ? 8'd255 : 8'(n);
            step(1'b0, 1'b0, cu + 8'd5, 1'b0, 1'b0, 1'b1, 1'b1, ecx);
            step(1'b0, 1'b0, cu, 1'b0, 1'b0, 1'b0, 1'b1, ecx);
            step(1'b0, 1'b0, cu, 1'b0, 1'b1, 1'b0, 1'b1, ecx);
        end
        chk8("errcnt_saturated", ec_u, 8'd255);

        // clr_err on the same edge as a new error: error wins
        step(1'b0, 1'b0, cu + 8'd5, 1'b1, 1'b0, 1'b1, 1'b1, 8'd1);
        step(1'b0, 1'b0, cu, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1);
        step(1'b0, 1'b0, cu, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1);
        step(1'b0, 1'b1, cu, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1);
        step(1'b0, 1'b1, cu, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1);

        // Asynchronous reset mid-count while locked
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_all_zero("async_rst");
        en_u = 1'b0; cnt_u = cu; en_d = 1'b0; cnt_d = cd;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            e = 1'($urandom_range(0, 1));
            step(1'b0, e, cu, 1'b0, (i >= LOCK_CYC), 1'b0, 1'b0, 8'd0);
        end

        @(posedge clk);
        #3;
        chk8("sb_drained", 8'(sb.size()), 8'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
